// File: rtl/ts_render_unit.sv
// Tile/sprite renderer: fetches 4bpp graphics words and writes coloured pixels into the line buffer.
// Optional X clipping at PIX_LIMIT is built when TS_RENDER_CLIP_EN is defined.
module ts_render_unit #(
  parameter int PIX_LIMIT = 360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsr_go,
  input  logic [5:0]  tsr_addr,
  input  logic [8:0]  tsr_line,
  input  logic [7:0]  tsr_page,
  input  logic [8:0]  tsr_x,
  input  logic [2:0]  tsr_xs,
  input  logic        tsr_xf,
  input  logic [3:0]  tsr_pal,
  output logic        tsr_rdy,
  output logic [20:0] dram_addr,
  output logic        dram_req,
  input  logic        dram_next,
  input  logic [15:0] dram_rdata,
  output logic [8:0]  lb_addr,
  output logic [7:0]  lb_data,
  output logic        lb_we
);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [7:0]  page_q;
  logic [8:0]  line_q;
  logic [5:0]  addr_q;
  logic [4:0]  words_q;
  logic [4:0]  wc;
  logic        xf_q;
  logic [3:0]  pal_q;
  logic [8:0]  x_cur;
  logic [15:0] hr;
  logic        hr_full;
  logic [15:0] sh;
  logic [2:0]  sh_cnt;

  logic [7:0]  page_sum;
  logic [6:0]  col;
  logic        load, emit, xfer, last, pix_ok;
  logic [3:0]  pix;

  assign page_sum  = page_q + {5'b0, line_q[8:6]};
  assign col       = {addr_q, 1'b0} + {2'b0, wc};
  assign dram_addr = {page_sum, line_q[5:0], col};
  assign dram_req  = (state == RUN) && (wc != words_q) && !hr_full;

  assign load = dram_req && dram_next;
  assign emit = (state == RUN) && (sh_cnt != 3'd0);
  // Refill the shifter while it emits its last nibble so words stream without bubbles.
  assign xfer = hr_full && (sh_cnt <= 3'd1);
  assign last = emit && (sh_cnt == 3'd1) && !hr_full && (wc == words_q);
  assign pix  = sh[15:12];

`ifdef TS_RENDER_CLIP_EN
  localparam logic [9:0] LIMIT = PIX_LIMIT[9:0];
  assign pix_ok = (pix != 4'd0) && ({1'b0, x_cur} < LIMIT);
`else
  assign pix_ok = (pix != 4'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tsr_rdy <= 1'b1;
      page_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
      wc      <= '0;
      xf_q    <= 1'b0;
      pal_q   <= '0;
      x_cur   <= '0;
      hr      <= '0;
      hr_full <= 1'b0;
      sh      <= '0;
      sh_cnt  <= '0;
      lb_we   <= 1'b0;
      lb_addr <= '0;
      lb_data <= '0;
    end else begin
      lb_we <= 1'b0;
      case (state)
        IDLE: begin
          if (tsr_go && tsr_rdy) begin
            page_q  <= tsr_page;
            line_q  <= tsr_line;
            addr_q  <= tsr_addr;
            words_q <= {1'b0, tsr_xs, 1'b0} + 5'd2;
            xf_q    <= tsr_xf;
            pal_q   <= tsr_pal;
            x_cur   <= tsr_xf ? (tsr_x + {3'b0, tsr_xs, 3'b111}) : tsr_x;
            wc      <= '0;
            hr_full <= 1'b0;
            sh_cnt  <= '0;
            state   <= RUN;
            tsr_rdy <= 1'b0;
          end
        end
        RUN: begin
          if (load) begin
            hr      <= dram_rdata;
            hr_full <= 1'b1;
            wc      <= wc + 5'd1;
          end else if (xfer) begin
            hr_full <= 1'b0;
          end
          if (xfer) begin
            sh     <= hr;
            sh_cnt <= 3'd4;
          end else if (emit) begin
            sh     <= {sh[11:0], 4'h0};
            sh_cnt <= sh_cnt - 3'd1;
          end
          if (emit) begin
            lb_we   <= pix_ok;
            lb_addr <= x_cur;
            lb_data <= {pal_q, pix};
            x_cur   <= xf_q ? (x_cur - 9'd1) : (x_cur + 9'd1);
          end
          if (last) begin
            state   <= IDLE;
            tsr_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_render_unit.sv
// Directed bench for ts_render_unit: a task-level model predicts DRAM addresses and line-buffer writes.
module tb_ts_render_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        tsr_go;
  logic [5:0]  tsr_addr;
  logic [8:0]  tsr_line;
  logic [7:0]  tsr_page;
  logic [8:0]  tsr_x;
  logic [2:0]  tsr_xs;
  logic        tsr_xf;
  logic [3:0]  tsr_pal;
  logic        tsr_rdy;
  logic [20:0] dram_addr;
  logic        dram_req;
  logic        dram_next;
  logic [15:0] dram_rdata;
  logic [8:0]  lb_addr;
  logic [7:0]  lb_data;
  logic        lb_we;

  ts_render_unit dut (
    .clk(clk), .rst(rst), .tsr_go(tsr_go), .tsr_addr(tsr_addr), .tsr_line(tsr_line),
    .tsr_page(tsr_page), .tsr_x(tsr_x), .tsr_xs(tsr_xs), .tsr_xf(tsr_xf), .tsr_pal(tsr_pal),
    .tsr_rdy(tsr_rdy), .dram_addr(dram_addr), .dram_req(dram_req), .dram_next(dram_next),
    .dram_rdata(dram_rdata), .lb_addr(lb_addr), .lb_data(lb_data), .lb_we(lb_we)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_wr[$];
  int exp_ad[$];
  int act_log[$];
  int ad_log[$];
  int wr_cyc[$];
  int words[16];
  int served = 0;
  int exp_n = 0;
  int next_period = 1;
  bit next_en = 1'b0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit on_screen(input int xi);
`ifdef TS_RENDER_CLIP_EN
    return xi < 360;
`else
    return xi >= 0;
`endif
  endfunction

  // Expected behaviour straight from the task description: one address per word,
  // one slot per nibble, transparent or clipped slots produce no write.
  task automatic build_model(input int page, input int line, input int addr, input int x,
                             input int xs, input int xf, input int pal);
    int n, pg, xi, nib;
    n = (xs + 1) * 2;
    exp_n = n;
    pg = (page + line / 64) % 256;
    for (int k = 0; k < n; k++)
      exp_ad.push_back(pg * 8192 + (line % 64) * 128 + (addr * 2 + k) % 128);
    for (int i = 0; i < n * 4; i++) begin
      nib = (words[i / 4] >> (12 - 4 * (i % 4))) & 15;
      xi = (xf != 0) ? (x + (xs + 1) * 8 - 1 - i) : (x + i);
      xi = xi % 512;
      if (nib != 0 && on_screen(xi)) exp_wr.push_back(xi * 256 + pal * 16 + nib);
    end
  endtask

  // DRAM responder: data for the next unconsumed word, next strobe on a fixed cadence.
  initial begin
    dram_next = 1'b0;
    dram_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      dram_next = next_en && (cyc % next_period == 0);
      dram_rdata = (served < 16) ? 16'(words[served]) : 16'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (lb_we) begin
        act_log.push_back(32'({lb_addr, lb_data}));
        wr_cyc.push_back(cyc);
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got %0h, want none", {lb_addr, lb_data});
        end else begin
          chk("lb_write", 32'({lb_addr, lb_data}), exp_wr.pop_front());
        end
      end
      if (dram_req && dram_next) begin
        ad_log.push_back(32'(dram_addr));
        if (exp_ad.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fetch: got %0h, want none", dram_addr);
        end else begin
          chk("dram_addr", 32'(dram_addr), exp_ad.pop_front());
        end
        served++;
      end
    end
  end

  task automatic set_fields(input int page, input int line, input int addr, input int x,
                            input int xs, input int xf, input int pal);
    tsr_page = 8'(page); tsr_line = 9'(line); tsr_addr = 6'(addr); tsr_x = 9'(x);
    tsr_xs = 3'(xs); tsr_xf = 1'(xf); tsr_pal = 4'(pal);
  endtask

  // Called at negedge+1 with tsr_rdy=1; acceptance happens on the next posedge.
  task automatic launch(input int page, input int line, input int addr, input int x,
                        input int xs, input int xf, input int pal, input int period);
    act_log.delete(); ad_log.delete(); wr_cyc.delete();
    build_model(page, line, addr, x, xs, xf, pal);
    served = 0;
    next_period = period;
    next_en = 1'b1;
    chk("rdy_before_go", 32'(tsr_rdy), 1);
    set_fields(page, line, addr, x, xs, xf, pal);
    tsr_go = 1'b1;
    @(negedge clk); #1;
    tsr_go = 1'b0;
    chk("rdy_after_accept", 32'(tsr_rdy), 0);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 1000 && !tsr_rdy; i++) begin
      @(negedge clk); #1;
    end
    chk({nm, "_finish"}, 32'(tsr_rdy), 1);
    chk({nm, "_pending_writes"}, exp_wr.size(), 0);
    chk({nm, "_words_fetched"}, served, exp_n);
    exp_wr.delete(); exp_ad.delete();
    next_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tsr_go = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_rdy", 32'(tsr_rdy), 1);
    chk("reset_req", 32'(dram_req), 0);
    chk("reset_we", 32'(lb_we), 0);
    chk("reset_lb_addr", 32'(lb_addr), 0);
    chk("reset_lb_data", 32'(lb_data), 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Baseline, forward
    words[0] = 'h1230; words[1] = 'h4567;
    launch('h10, 'h045, 3, 100, 0, 0, 5, 1);
    wait_done("base");
    chk("base_nwrites", act_log.size(), 7);
    chk("base_w0", act_log[0], 100 * 256 + 'h51);
    chk("base_w3", act_log[3], 104 * 256 + 'h54);
    chk("base_w6", act_log[6], 107 * 256 + 'h57);
    chk("base_ad0", ad_log[0], 'h22286);
    chk("base_ad1", ad_log[1], 'h22287);

    // Baseline, flipped
    launch('h10, 'h045, 3, 100, 0, 1, 5, 1);
    wait_done("flip");
    chk("flip_w0", act_log[0], 107 * 256 + 'h51);
    chk("flip_w3", act_log[3], 103 * 256 + 'h54);
    chk("flip_w6", act_log[6], 100 * 256 + 'h57);

    // Widest task, slow DRAM, column and page wrap
    for (int k = 0; k < 16; k++)
      words[k] = (((k % 15) + 1) << 12) | ((((k + 3) % 15) + 1) << 8)
               | ((((k + 7) % 15) + 1) << 4) | (((k + 11) % 15) + 1);
    launch('hFF, 'h1C0, 63, 20, 7, 0, 6, 3);
    wait_done("wide");
    chk("wide_nwrites", act_log.size(), 64);
    chk("wide_ad0", ad_log[0], 'hC07E);
    chk("wide_ad2", ad_log[2], 'hC000);
    chk("wide_ad15", ad_log[15], 'hC00D);

    // Full-rate streaming: 32 opaque pixels on consecutive cycles
    launch(1, 2, 0, 10, 3, 0, 2, 1);
    wait_done("rate");
    chk("rate_nwrites", act_log.size(), 32);
    chk("rate_span", wr_cyc[31] - wr_cyc[0], 31);

    // X wrap at 512
    words[0] = 'h1111; words[1] = 'h1111;
    launch(0, 0, 0, 508, 0, 0, 3, 1);
    wait_done("wrap");
`ifdef TS_RENDER_CLIP_EN
    chk("wrap_nwrites", act_log.size(), 4);
    chk("wrap_w0", act_log[0], 0 * 256 + 'h31);
`else
    chk("wrap_nwrites", act_log.size(), 8);
    chk("wrap_w0", act_log[0], 508 * 256 + 'h31);
    chk("wrap_w4", act_log[4], 0 * 256 + 'h31);
`endif

    // Held tsr_go: second field set only taken when tsr_rdy returns
    words[0] = 'h1230; words[1] = 'h4567;
    act_log.delete(); ad_log.delete(); wr_cyc.delete();
    build_model('h10, 'h045, 3, 100, 0, 0, 5);
    served = 0; next_period = 1; next_en = 1'b1;
    set_fields('h10, 'h045, 3, 100, 0, 0, 5);
    tsr_go = 1'b1;
    @(negedge clk); #1;
    chk("hold_accept", 32'(tsr_rdy), 0);
    set_fields('h10, 'h045, 3, 200, 0, 0, 9);
    for (int i = 0; i < 1000 && !tsr_rdy; i++) begin
      @(negedge clk); #1;
    end
    chk("hold_first_done", 32'(tsr_rdy), 1);
    chk("hold_first_writes", exp_wr.size(), 0);
    build_model('h10, 'h045, 3, 200, 0, 0, 9);
    served = 0;
    @(negedge clk); #1;
    chk("b2b_accept", 32'(tsr_rdy), 0);
    tsr_go = 1'b0;
    wait_done("b2b");
    chk("b2b_nwrites", act_log.size(), 14);
    chk("b2b_last", act_log[13], 207 * 256 + 'h97);

    // Reset in the middle of a task
    launch('h10, 'h045, 3, 100, 0, 0, 5, 1);
    for (int i = 0; i < 200 && act_log.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_two_pixels", act_log.size(), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(tsr_rdy), 1);
    chk("mid_rst_req", 32'(dram_req), 0);
    chk("mid_rst_we", 32'(lb_we), 0);
    exp_wr.delete(); exp_ad.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    act_log.delete(); ad_log.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
    end
    chk("post_rst_no_writes", act_log.size(), 0);
    chk("post_rst_no_fetch", ad_log.size(), 0);
    next_en = 1'b0;
    launch('h10, 'h045, 3, 100, 0, 0, 5, 1);
    wait_done("after_rst");
    chk("after_rst_nwrites", act_log.size(), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
